triangle_rasterizer: RTL and testbench

TRIANGLE_RASTERIZER -- requirements
Module: triangle_rasterizer

---
 rtl/triangle_rasterizer.sv | 219 +++++++++++++++++++++
 tb/tb_triangle_rasterizer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_rasterizer.sv
// Scan-converts one attributed triangle at a time into barycentric-weighted
// fragments, testing every pixel of the clamped bounding box in row-major order.
package triangle_rasterizer_pkg;
    localparam int unsigned FIX_W    = 40;
    localparam int unsigned FIX_FRAC = 16;
    localparam int unsigned INT_W    = FIX_W - FIX_FRAC;
    localparam int unsigned PROD_W   = 2 * FIX_W;

    typedef logic signed [FIX_W-1:0] fixed_t;
    typedef logic signed [INT_W-1:0] fint_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
    } vec2_t;

    typedef struct packed {
        vec2_t a;
        vec2_t b;
        vec2_t c;
    } triangle_t;

    typedef struct packed {
        triangle_t triangle;
        fixed_t    area_inv;
    } attributed_triangle_t;

    typedef struct packed {
        logic [15:0] triangle_id;
        logic [15:0] material_id;
    } triangle_metadata_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        fixed_t      w_a;
        fixed_t      w_b;
        fixed_t      w_c;
    } fragment_t;

    function automatic fixed_t fixed_sub(input fixed_t a, input fixed_t b);
        return a - b;
    endfunction

    // Full-width product, rescaled back to Q(INT_W).FIX_FRAC with floor rounding.
    function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return fixed_t'(p >>> FIX_FRAC);
    endfunction

    function automatic fint_t ftoi(input fixed_t f);
        return fint_t'(f >>> FIX_FRAC);
    endfunction

    function automatic fixed_t itof(input logic [15:0] v);
        return fixed_t'(v) <<< FIX_FRAC;
    endfunction

    // Twice the signed area of (a,b,c); positive for counter-clockwise winding.
    function automatic fixed_t triangle_area(input vec2_t a, input vec2_t b, input vec2_t c);
        return fixed_sub(fixed_mul(fixed_sub(b.x, a.x), fixed_sub(c.y, a.y)),
                         fixed_mul(fixed_sub(c.x, a.x), fixed_sub(b.y, a.y)));
    endfunction
endpackage

module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 attributed_triangle_s_ready,
    input  logic                 attributed_triangle_s_valid,
    input  attributed_triangle_t attributed_triangle_s_data,
    input  triangle_metadata_t   attributed_triangle_s_metadata,
    input  logic                 fragment_m_ready,
    output logic                 fragment_m_valid,
    output fragment_t            fragment_m_data,
    output triangle_metadata_t   fragment_m_metadata,
    output logic                 busy
);
    localparam int unsigned COORD_W = 16;
    localparam fint_t X_LIMIT = fint_t'(SCREEN_WIDTH - 1);
    localparam fint_t Y_LIMIT = fint_t'(SCREEN_HEIGHT - 1);
    localparam fint_t ZERO_I  = '0;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, EMIT} state_e;

    state_e               state_q;
    attributed_triangle_t tri_q;
    triangle_metadata_t   meta_q;
    logic [COORD_W-1:0]   x_q, y_q, min_x_q, max_x_q, max_y_q;
    fragment_t            frag_q;
    triangle_metadata_t   frag_meta_q;

    function automatic fint_t min3(input fint_t a, input fint_t b, input fint_t c);
        fint_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic fint_t max3(input fint_t a, input fint_t b, input fint_t c);
        fint_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input fint_t v, input fint_t lim);
        if (v < ZERO_I) return '0;
        if (v > lim)    return COORD_W'(lim);
        return COORD_W'(v);
    endfunction

    // Bounding box of the latched triangle, evaluated during SETUP.
    fint_t bb_min_x_c, bb_max_x_c, bb_min_y_c, bb_max_y_c;
    logic  reject_c;

    assign bb_min_x_c = min3(ftoi(tri_q.triangle.a.x), ftoi(tri_q.triangle.b.x), ftoi(tri_q.triangle.c.x));
    assign bb_max_x_c = max3(ftoi(tri_q.triangle.a.x), ftoi(tri_q.triangle.b.x), ftoi(tri_q.triangle.c.x));
    assign bb_min_y_c = min3(ftoi(tri_q.triangle.a.y), ftoi(tri_q.triangle.b.y), ftoi(tri_q.triangle.c.y));
    assign bb_max_y_c = max3(ftoi(tri_q.triangle.a.y), ftoi(tri_q.triangle.b.y), ftoi(tri_q.triangle.c.y));

    assign reject_c = (tri_q.area_inv == '0)
                    || (bb_max_x_c < ZERO_I) || (bb_min_x_c > X_LIMIT)
                    || (bb_max_y_c < ZERO_I) || (bb_min_y_c > Y_LIMIT);

    // Barycentric weights of the cursor pixel; zero weights count as inside.
    vec2_t  p_c;
    fixed_t w_a_c, w_b_c, w_c_c;
    logic   inside_c, last_c;
    logic [COORD_W-1:0] next_x_c, next_y_c;

    assign p_c   = '{x: itof(x_q), y: itof(y_q)};
    assign w_a_c = fixed_mul(triangle_area(p_c, tri_q.triangle.b, tri_q.triangle.c), tri_q.area_inv);
    assign w_b_c = fixed_mul(triangle_area(tri_q.triangle.a, p_c, tri_q.triangle.c), tri_q.area_inv);
    assign w_c_c = fixed_mul(triangle_area(tri_q.triangle.a, tri_q.triangle.b, p_c), tri_q.area_inv);

    assign inside_c = ~w_a_c[FIX_W-1] & ~w_b_c[FIX_W-1] & ~w_c_c[FIX_W-1];
    assign last_c   = (x_q == max_x_q) && (y_q == max_y_q);

    always_comb begin
        next_x_c = x_q + COORD_W'(1);
        next_y_c = y_q;
        if (x_q == max_x_q) begin
            next_x_c = min_x_q;
            next_y_c = y_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            tri_q       <= '0;
            meta_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            max_y_q     <= '0;
            frag_q      <= '0;
            frag_meta_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (attributed_triangle_s_valid) begin
                        tri_q   <= attributed_triangle_s_data;
                        meta_q  <= attributed_triangle_s_metadata;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (reject_c) begin
                        state_q <= IDLE;
                    end else begin
                        x_q     <= clamp(bb_min_x_c, X_LIMIT);
                        y_q     <= clamp(bb_min_y_c, Y_LIMIT);
                        min_x_q <= clamp(bb_min_x_c, X_LIMIT);
                        max_x_q <= clamp(bb_max_x_c, X_LIMIT);
                        max_y_q <= clamp(bb_max_y_c, Y_LIMIT);
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (inside_c) begin
                        frag_q      <= '{x: x_q, y: y_q, w_a: w_a_c, w_b: w_b_c, w_c: w_c_c};
                        frag_meta_q <= meta_q;
                        state_q     <= EMIT;
                    end else if (last_c) begin
                        state_q <= IDLE;
                    end else begin
                        x_q <= next_x_c;
                        y_q <= next_y_c;
                    end
                end
                EMIT: begin
                    if (fragment_m_ready) begin
                        if (last_c) begin
                            state_q <= IDLE;
                        end else begin
                            x_q     <= next_x_c;
                            y_q     <= next_y_c;
                            state_q <= SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign attributed_triangle_s_ready = (state_q == IDLE);
    assign fragment_m_valid            = (state_q == EMIT);
    assign busy                        = (state_q != IDLE);
    assign fragment_m_data             = frag_q;
    assign fragment_m_metadata         = frag_meta_q;
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: a table of triangles with hand-derived
// fragment counts and weights, plus stall, clamp and mid-stream reset sequences.
module tb_triangle_rasterizer;
    import triangle_rasterizer_pkg::*;

    localparam fixed_t ONE  = fixed_t'(65536);
    localparam fixed_t HALF = fixed_t'(32768);
    localparam fixed_t Q16  = fixed_t'(4096);

    logic                 clk;
    logic                 rstn;
    logic                 s_ready;
    logic                 s_valid;
    attributed_triangle_t s_data;
    triangle_metadata_t   s_meta;
    logic                 m_ready;
    logic                 m_valid;
    fragment_t            m_data;
    triangle_metadata_t   m_meta;
    logic                 busy;

    triangle_rasterizer dut (
        .clk                            (clk),
        .rstn                           (rstn),
        .attributed_triangle_s_ready    (s_ready),
        .attributed_triangle_s_valid    (s_valid),
        .attributed_triangle_s_data     (s_data),
        .attributed_triangle_s_metadata (s_meta),
        .fragment_m_ready               (m_ready),
        .fragment_m_valid               (m_valid),
        .fragment_m_data                (m_data),
        .fragment_m_metadata            (m_meta),
        .busy                           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        fragment_t          d;
        triangle_metadata_t m;
    } rec_t;

    typedef struct {
        int     ax, ay, bx, by, cx, cy;
        fixed_t inv;
        int     n;
        int     f_x, f_y;
        fixed_t f_wa, f_wb, f_wc;
        int     l_x, l_y;
        int     k;
        int     k_x, k_y;
        fixed_t k_wa, k_wb, k_wc;
    } vec_t;

    rec_t got[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[6];

    always @(posedge clk) begin
        if (m_valid && m_ready) got.push_back('{d: m_data, m: m_meta});
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic fixed_t fx(input int v);
        return fixed_t'(v) <<< 16;
    endfunction

    function automatic attributed_triangle_t mk_tri(input vec_t v);
        attributed_triangle_t t;
        t.triangle.a.x = fx(v.ax);
        t.triangle.a.y = fx(v.ay);
        t.triangle.b.x = fx(v.bx);
        t.triangle.b.y = fx(v.by);
        t.triangle.c.x = fx(v.cx);
        t.triangle.c.y = fx(v.cy);
        t.area_inv     = v.inv;
        return t;
    endfunction

    task automatic wait_idle(input int bound, input string name);
        int i;
        i = 0;
        while (busy && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk(name, busy, 0);
    endtask

    // Presents one triangle while the DUT is idle; returns #1 after the accepting edge.
    task automatic accept(input attributed_triangle_t t, input triangle_metadata_t md);
        chk("ready_before_accept", s_ready, 1);
        s_data  = t;
        s_meta  = md;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic count_order_and_meta(input triangle_metadata_t md, output int bad_order, output int bad_meta);
        bad_order = 0;
        bad_meta  = 0;
        foreach (got[i]) begin
            if (got[i].m !== md) bad_meta++;
            if (i > 0) begin
                if (!((got[i].d.y > got[i-1].d.y) ||
                      (got[i].d.y == got[i-1].d.y && got[i].d.x > got[i-1].d.x))) bad_order++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input triangle_metadata_t md);
        int bo, bm;
        got.delete();
        accept(mk_tri(v), md);
        chk("setup_busy", busy, 1);
        chk("setup_ready", s_ready, 0);
        chk("setup_valid", m_valid, 0);
        @(posedge clk);
        #1;
        if (v.n == 0) begin
            chk("reject_ready", s_ready, 1);
            chk("reject_busy", busy, 0);
            chk("reject_valid", m_valid, 0);
        end else begin
            chk("scan_valid", m_valid, 0);
            @(posedge clk);
            #1;
            chk("first_latency_valid", m_valid, 1);
        end
        wait_idle(2000, "idle_timeout");
        chk("frag_count", got.size(), v.n);
        if (v.n > 0 && got.size() == v.n) begin
            chk("first_x", got[0].d.x, v.f_x);
            chk("first_y", got[0].d.y, v.f_y);
            chk("first_wa", got[0].d.w_a, v.f_wa);
            chk("first_wb", got[0].d.w_b, v.f_wb);
            chk("first_wc", got[0].d.w_c, v.f_wc);
            chk("last_x", got[v.n-1].d.x, v.l_x);
            chk("last_y", got[v.n-1].d.y, v.l_y);
            chk("idx_x", got[v.k].d.x, v.k_x);
            chk("idx_y", got[v.k].d.y, v.k_y);
            chk("idx_wa", got[v.k].d.w_a, v.k_wa);
            chk("idx_wb", got[v.k].d.w_b, v.k_wb);
            chk("idx_wc", got[v.k].d.w_c, v.k_wc);
            count_order_and_meta(md, bo, bm);
            chk("order_violations", bo, 0);
            chk("meta_mismatches", bm, 0);
        end
    endtask

    initial begin
        int bo, bm, oor, i;
        triangle_metadata_t md;

        tbl[0] = '{0, 0, 4, 0, 0, 4, Q16, 15, 0, 0, ONE, 0, 0, 0, 4, 4, 4, 0, 0, ONE, 0};
        tbl[1] = '{0, 0, 2, 2, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{-10, 0, -5, 0, -10, 5, fixed_t'(2621), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{10, 10, 12, 10, 10, 12, fixed_t'(16384), 6, 10, 10, ONE, 0, 0, 10, 12, 1, 11, 10, HALF, HALF, 0};
        tbl[4] = '{318, 0, 322, 0, 318, 4, Q16, 9, 318, 0, ONE, 0, 0, 318, 4, 1, 319, 0, fixed_t'(49152), fixed_t'(16384), 0};
        tbl[5] = '{0, 0, 0, 4, 4, 0, fixed_t'(-4096), 15, 0, 0, ONE, 0, 0, 0, 4, 4, 4, 0, 0, 0, ONE};

        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_meta  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", s_ready, 1);
        chk("reset_valid", m_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", m_data.x, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            md = '{triangle_id: 16'(100 + t), material_id: 16'(7 * t + 3)};
            run_vec(tbl[t], md);
        end

        // Downstream stall on the first fragment.
        got.delete();
        md = '{triangle_id: 16'hBEEF, material_id: 16'h0042};
        m_ready = 1'b0;
        accept(mk_tri(tbl[0]), md);
        i = 0;
        while (!m_valid && i < 10) begin
            @(posedge clk);
            #1;
            i++;
        end
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_x", m_data.x, 0);
            chk("stall_y", m_data.y, 0);
            chk("stall_wa", m_data.w_a, ONE);
            chk("stall_meta", m_meta.triangle_id, 16'hBEEF);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        wait_idle(2000, "stall_idle_timeout");
        chk("stall_count", got.size(), 15);
        count_order_and_meta(md, bo, bm);
        chk("stall_order", bo, 0);
        chk("stall_meta_mismatches", bm, 0);

        // Box larger than the screen on every side: fragments must stay on-screen.
        got.delete();
        md = '{triangle_id: 16'd555, material_id: 16'd1};
        accept(mk_tri('{-5, -5, 400, 300, -5, -4, fixed_t'(162), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}), md);
        wait_idle(90000, "clamp_idle_timeout");
        oor = 0;
        foreach (got[j]) begin
            if (got[j].d.x > 16'd319 || got[j].d.y > 16'd239) oor++;
        end
        chk("clamp_nonempty", (got.size() > 0), 1);
        chk("clamp_out_of_range", oor, 0);
        count_order_and_meta(md, bo, bm);
        chk("clamp_order", bo, 0);

        // Reset while the fourth fragment is being presented.
        got.delete();
        md = '{triangle_id: 16'd77, material_id: 16'd9};
        accept(mk_tri(tbl[0]), md);
        i = 0;
        while (got.size() < 3 && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("rst_pre_count", got.size(), 3);
        @(posedge clk);
        #1;
        chk("rst_pre_valid", m_valid, 1);
        rstn = 1'b0;
        #1;
        chk("rst_valid_drop", m_valid, 0);
        chk("rst_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_stray", got.size(), 3);
        chk("rst_post_ready", s_ready, 1);
        chk("rst_post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
